// File: rtl/lut_12bit_1s.sv
// Two-stage registered population count of a 12-bit word.
// Three nibble lookups feed stage 1; their sum and derived flags form stage 2.
module lut_12bit_1s (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [11:0] bits,
  output logic        out_valid,
  output logic [4:0]  count,
  output logic        is_zero,
  output logic        is_full,
  output logic        parity
);

  function automatic logic [2:0] nib_pop(input logic [3:0] k);
    logic [2:0] r;
    case (k)
      4'h0: r = 3'd0;
      4'h1: r = 3'd1;
      4'h2: r = 3'd1;
      4'h3: r = 3'd2;
      4'h4: r = 3'd1;
      4'h5: r = 3'd2;
      4'h6: r = 3'd2;
      4'h7: r = 3'd3;
      4'h8: r = 3'd1;
      4'h9: r = 3'd2;
      4'ha: r = 3'd2;
      4'hb: r = 3'd3;
      4'hc: r = 3'd2;
      4'hd: r = 3'd3;
      4'he: r = 3'd3;
      4'hf: r = 3'd4;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

  logic [2:0] c0, c1, c2;
  logic       v1;
  logic [4:0] sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c0 <= 3'd0;
      c1 <= 3'd0;
      c2 <= 3'd0;
      v1 <= 1'b0;
    end else begin
      c0 <= nib_pop(bits[3:0]);
      c1 <= nib_pop(bits[7:4]);
      c2 <= nib_pop(bits[11:8]);
      v1 <= in_valid;
    end
  end

  // Max 4+4+4 = 12, so a 5-bit sum never overflows.
  assign sum = {2'b00, c0} + {2'b00, c1} + {2'b00, c2};

  // is_zero resets high so the flag stays consistent with count = 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      count     <= 5'd0;
      is_zero   <= 1'b1;
      is_full   <= 1'b0;
      parity    <= 1'b0;
    end else begin
      out_valid <= v1;
      count     <= sum;
      is_zero   <= (sum == 5'd0);
      is_full   <= (sum == 5'd12);
      parity    <= sum[0];
    end
  end

endmodule

// File: tb/tb_lut_12bit_1s.sv
// Self-checking bench for lut_12bit_1s: directed table, gaps, async reset,
// exhaustive sweep and random traffic against a bit-counting reference.
module tb_lut_12bit_1s;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [11:0] bits;
  logic        out_valid;
  logic [4:0]  count;
  logic        is_zero;
  logic        is_full;
  logic        parity;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       v;
    logic [4:0] cnt;
  } exp_t;

  typedef struct {
    logic [11:0] bits;
    int          cnt;
  } vec_t;

  exp_t pipe[$];
  vec_t vecs[$];

  lut_12bit_1s dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .bits(bits),
    .out_valid(out_valid), .count(count), .is_zero(is_zero),
    .is_full(is_full), .parity(parity)
  );

  always #5 clk = ~clk;

  function automatic int ref_pop(input logic [11:0] w);
    int n = 0;
    for (int i = 0; i < 12; i++) if (w[i]) n++;
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, want, $time);
    end
  endtask

  // Drive one cycle; tcnt < 0 means take the expectation from the reference.
  task automatic step(input logic v, input logic [11:0] b, input int tcnt);
    exp_t e;
    in_valid = v;
    bits     = b;
    @(posedge clk);
    #1;
    e.v   = v;
    e.cnt = (tcnt < 0) ? 5'(ref_pop(b)) : 5'(tcnt);
    pipe.push_back(e);
    if (pipe.size() > 2) pipe.delete(0);
    if (pipe.size() == 2 && pipe[0].v) begin
      e = pipe[0];
      chk("out_valid", int'(out_valid), 1);
      chk("count", int'(count), int'(e.cnt));
      chk("is_zero", int'(is_zero), int'(e.cnt == 0));
      chk("is_full", int'(is_full), int'(e.cnt == 12));
      chk("parity", int'(parity), int'(e.cnt) % 2);
    end else begin
      chk("out_valid_idle", int'(out_valid), 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_is_zero"}, int'(is_zero), 1);
    chk({tag, "_is_full"}, int'(is_full), 0);
    chk({tag, "_parity"}, int'(parity), 0);
  endtask

  initial begin
    vecs = '{
      '{12'd0, 0}, '{12'd1, 1}, '{12'd2, 1}, '{12'd3, 2}, '{12'd4, 1},
      '{12'd5, 2}, '{12'd6, 2}, '{12'd7, 3}, '{12'd8, 1}, '{12'd9, 2},
      '{12'd10, 2},
      '{12'h000, 0}, '{12'hFFF, 12}, '{12'h800, 1},
      '{12'h00F, 4}, '{12'h0F0, 4}, '{12'hF00, 4}, '{12'h0FF, 8},
      '{12'hF0F, 8}, '{12'hAAA, 6}, '{12'h555, 6}
    };

    rst = 1'b1; in_valid = 1'b0; bits = 12'h0;
    #1;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    pipe.delete();

    foreach (vecs[i]) step(1'b1, vecs[i].bits, vecs[i].cnt);
    step(1'b0, 12'h000, -1);
    step(1'b0, 12'h000, -1);

    // valid gaps 1,0,1,1
    step(1'b1, 12'h3C3, 6);
    step(1'b0, 12'hFFF, -1);
    step(1'b1, 12'h801, 2);
    step(1'b1, 12'h7FF, 11);
    step(1'b0, 12'h000, -1);
    step(1'b0, 12'h000, -1);

    // async reset with two words in flight
    step(1'b1, 12'hFFF, 12);
    step(1'b1, 12'h7FF, 11);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async");
    @(posedge clk);
    #1;
    check_reset_outputs("held");
    rst = 1'b0;
    pipe.delete();
    repeat (3) step(1'b0, 12'h000, -1);
    step(1'b1, 12'h00F, 4);

    for (int w = 0; w < 4096; w++) step(1'b1, 12'(w), -1);

    repeat (600) step(1'($urandom_range(0, 1)), 12'($urandom), -1);
    step(1'b0, 12'h000, -1);
    step(1'b0, 12'h000, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
